// File: rtl/bp_fe_queue_rolly_pkg.sv
// Shared types and depth constant for the FE queue.
// FE and BE credit logic both size themselves from fe_queue_els_gp.
package bp_fe_queue_rolly_pkg;

   localparam int fe_queue_els_gp = 8;

   typedef struct packed {
      logic [7:0]  msg_type;
      logic [31:0] instr;
   } bp_fe_queue_s;

   // index bits plus one wrap bit
   function automatic int ptr_width(input int els);
      return $clog2(els) + 1;
   endfunction

endpackage

// File: rtl/bp_fe_queue_rolly_mem.sv
// 1r1w storage for the FE queue, asynchronous read.
// Contents are intentionally not reset.
module bp_fe_queue_rolly_mem #(
   parameter int width_p = 8,
   parameter int els_p   = 8,
   parameter int addr_w_p = $clog2(els_p)
) (
   input  logic                clk_i,
   input  logic                w_v_i,
   input  logic [addr_w_p-1:0] w_addr_i,
   input  logic [width_p-1:0]  w_data_i,
   input  logic [addr_w_p-1:0] r_addr_i,
   output logic [width_p-1:0]  r_data_o
);

   logic [width_p-1:0] mem [els_p];

   // write port, no reset on storage
   always_ff @(posedge clk_i) begin
      if (w_v_i)
         mem[w_addr_i] <= w_data_i;
   end

   assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_rolly.sv
// Replayable FE queue: write, speculative read and commit pointers.
// Optional checks enabled by defining BP_FE_QUEUE_ASSERT_EN.
module bp_fe_queue_rolly
   import bp_fe_queue_rolly_pkg::*;
#(
   parameter int width_p = $bits(bp_fe_queue_s),
   parameter int els_p   = fe_queue_els_gp
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] fe_queue_i,
   input  logic               fe_queue_v_i,
   output logic               fe_queue_ready_o,
   output logic [width_p-1:0] fe_queue_o,
   output logic               fe_queue_v_o,
   input  logic               fe_queue_yumi_i,
   input  logic               fe_queue_deq_i,
   input  logic               fe_queue_roll_i,
   input  logic               fe_queue_clr_i,
   output logic               empty_o
);

   localparam int ptr_width_lp = ptr_width(els_p);
   localparam int idx_w_lp     = ptr_width_lp - 1;

   typedef logic [ptr_width_lp-1:0] ptr_t;

   ptr_t wptr_r, rptr_r, cptr_r;
   ptr_t wptr_n, rptr_n, cptr_n;
   logic full;
   logic enq;

   assign full = (wptr_r[idx_w_lp-1:0] == cptr_r[idx_w_lp-1:0])
               & (wptr_r[idx_w_lp] != cptr_r[idx_w_lp]);

   assign fe_queue_ready_o = ~full;
   assign fe_queue_v_o     = (rptr_r != wptr_r);
   assign empty_o          = (wptr_r == cptr_r);
   assign enq = fe_queue_v_i & ~full & ~fe_queue_clr_i;

   // pointer next-state: roll beats yumi, clr snaps wptr to new rptr
   always_comb begin
      cptr_n = cptr_r + ptr_t'(fe_queue_deq_i);
      rptr_n = rptr_r + ptr_t'(fe_queue_yumi_i);
      if (fe_queue_roll_i)
         rptr_n = cptr_n;
      wptr_n = wptr_r + ptr_t'(enq);
      if (fe_queue_clr_i)
         wptr_n = rptr_n;
   end

   // pointer registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
         cptr_r <= '0;
      end else begin
         wptr_r <= wptr_n;
         rptr_r <= rptr_n;
         cptr_r <= cptr_n;
      end
   end

   bp_fe_queue_rolly_mem #(
      .width_p (width_p),
      .els_p   (els_p),
      .addr_w_p(idx_w_lp)
   ) mem (
      .clk_i   (clk_i),
      .w_v_i   (enq),
      .w_addr_i(wptr_r[idx_w_lp-1:0]),
      .w_data_i(fe_queue_i),
      .r_addr_i(rptr_r[idx_w_lp-1:0]),
      .r_data_o(fe_queue_o)
   );

`ifdef BP_FE_QUEUE_ASSERT_EN
   logic               prev_v;
   logic               prev_ready;
   logic [width_p-1:0] prev_data;
   ptr_t               occ;

   assign occ = wptr_r - cptr_r;

   // remember last cycle's handshake for the hold check
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         prev_v     <= 1'b0;
         prev_ready <= 1'b1;
         prev_data  <= '0;
      end else begin
         prev_v     <= fe_queue_v_i;
         prev_ready <= fe_queue_ready_o;
         prev_data  <= fe_queue_i;
      end
   end

   // protocol checks on BE and FE behaviour
   always @(posedge clk_i) begin
      if (reset_n_i) begin
         if (fe_queue_yumi_i & ~fe_queue_v_o)
            $error("yumi with no unread entry");
         if (fe_queue_deq_i & (cptr_r == rptr_r))
            $error("deq of unread entry");
         if (prev_v & fe_queue_v_i & ~prev_ready
             & (fe_queue_i != prev_data))
            $error("fe_queue_i changed while stalled");
         if (occ > ptr_t'(els_p))
            $error("occupancy exceeds depth");
      end
   end
`else
   // checks compiled out; datapath is identical
`endif

endmodule

// File: tb/tb_bp_fe_queue_rolly.sv
// Scoreboard bench for bp_fe_queue_rolly.
// Model keeps uncommitted entries plus a read count.
module tb_bp_fe_queue_rolly;
   import bp_fe_queue_rolly_pkg::*;

   localparam int W = $bits(bp_fe_queue_s);
   localparam int N = fe_queue_els_gp;

   logic         clk_i = 1'b0;
   logic         reset_n_i;
   logic [W-1:0] fe_queue_i;
   logic         fe_queue_v_i;
   logic         fe_queue_ready_o;
   logic [W-1:0] fe_queue_o;
   logic         fe_queue_v_o;
   logic         fe_queue_yumi_i;
   logic         fe_queue_deq_i;
   logic         fe_queue_roll_i;
   logic         fe_queue_clr_i;
   logic         empty_o;

   bp_fe_queue_rolly dut (
      .clk_i           (clk_i),
      .reset_n_i       (reset_n_i),
      .fe_queue_i      (fe_queue_i),
      .fe_queue_v_i    (fe_queue_v_i),
      .fe_queue_ready_o(fe_queue_ready_o),
      .fe_queue_o      (fe_queue_o),
      .fe_queue_v_o    (fe_queue_v_o),
      .fe_queue_yumi_i (fe_queue_yumi_i),
      .fe_queue_deq_i  (fe_queue_deq_i),
      .fe_queue_roll_i (fe_queue_roll_i),
      .fe_queue_clr_i  (fe_queue_clr_i),
      .empty_o         (empty_o)
   );

   always #5 clk_i = ~clk_i;

   logic [W-1:0] mq [$];
   int rd;
   int n_chk;
   int n_pass;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // check outputs, drive one cycle, advance model
   task automatic cyc(input bit v, input logic [W-1:0] d,
                      input bit y, input bit dq,
                      input bit r, input bit c,
                      output bit acc);
      chk("ready", fe_queue_ready_o, mq.size() < N);
      chk("v_o", fe_queue_v_o, rd < mq.size());
      chk("empty", empty_o, mq.size() == 0);
      if (rd < mq.size())
         chk("data", fe_queue_o, mq[rd]);
      acc = v && (mq.size() < N) && !c;
      fe_queue_v_i    = v;
      fe_queue_i      = d;
      fe_queue_yumi_i = y;
      fe_queue_deq_i  = dq;
      fe_queue_roll_i = r;
      fe_queue_clr_i  = c;
      if (dq) begin
         void'(mq.pop_front());
         rd--;
      end
      if (r) rd = 0;
      else if (y) rd++;
      if (c)
         while (mq.size() > rd) void'(mq.pop_back());
      if (acc) mq.push_back(d);
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic enq(input logic [W-1:0] d);
      bit a;
      cyc(1, d, 0, 0, 0, 0, a);
   endtask

   task automatic idle();
      bit a;
      cyc(0, '0, 0, 0, 0, 0, a);
   endtask

   task automatic be(input bit y, input bit dq, input bit r);
      bit a;
      cyc(0, '0, y, dq, r, 0, a);
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      #1;
      chk("rst_ready", fe_queue_ready_o, 1);
      chk("rst_v", fe_queue_v_o, 0);
      chk("rst_empty", empty_o, 1);
      mq.delete();
      rd = 0;
      @(negedge clk_i);
      reset_n_i = 1'b1;
   endtask

   initial begin
      bit a, v, y, dq, r;
      int sent, cycles;
      n_chk = 0;
      n_pass = 0;
      rd = 0;
      reset_n_i = 1'b0;
      fe_queue_i = '0;
      fe_queue_v_i = 0;
      fe_queue_yumi_i = 0;
      fe_queue_deq_i = 0;
      fe_queue_roll_i = 0;
      fe_queue_clr_i = 0;
      @(negedge clk_i);
      do_reset();

      // fill to full, 9th not accepted
      for (int i = 0; i < N; i++) enq(W'(8'hA0 + i));
      cyc(1, W'(8'hA8), 0, 0, 0, 0, a);
      chk("ninth_acc", a, 0);
      idle();
      do_reset();

      // read two, commit one, roll
      enq(W'(8'h11));
      enq(W'(8'h22));
      enq(W'(8'h33));
      be(1, 0, 0);
      be(1, 0, 0);
      be(0, 1, 0);
      be(0, 0, 1);
      be(1, 0, 0);
      be(1, 1, 0);
      be(0, 1, 0);
      idle();
      do_reset();

      // clr with coincident enqueue, then roll
      for (int i = 0; i < 4; i++) enq(W'(8'h41 + i));
      be(1, 0, 0);
      cyc(1, W'(8'h99), 0, 0, 0, 1, a);
      idle();
      be(0, 0, 1);
      idle();
      be(1, 0, 0);
      be(0, 1, 0);
      idle();
      do_reset();

      // deq while full, then enqueue across the wrap
      for (int i = 0; i < N; i++) enq(W'(8'hB0 + i));
      be(1, 0, 0);
      be(0, 1, 0);
      idle();
      enq(W'(8'hB8));
      for (int i = 0; i < N; i++) be(1, rd > 0, 0);
      be(0, 1, 0);
      idle();
      do_reset();

      // deq+roll+clr together
      for (int i = 0; i < 5; i++) enq(W'(8'hC0 + i));
      for (int i = 0; i < 3; i++) be(1, 0, 0);
      be(0, 1, 1);
      fe_queue_clr_i = 1'b1;
      cyc(0, '0, 0, 1, 1, 1, a);
      idle();
      enq(W'(8'hC5));
      idle();
      do_reset();

      // random stream with periodic rolls
      sent = 0;
      cycles = 0;
      while ((sent < 40 || mq.size() > 0) && cycles < 3000) begin
         v  = (sent < 40) && ($urandom_range(0, 3) != 0);
         r  = (cycles % 7) == 6;
         y  = (rd < mq.size()) && ($urandom_range(0, 1) == 1);
         dq = (rd > 0) && ((rd >= 3) || ($urandom_range(0, 1) == 1));
         cyc(v, W'(32'hD000 + sent), y, dq, r, 0, a);
         if (a) sent++;
         cycles++;
      end
      chk("stream_done", cycles < 3000, 1);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
